prbs_gen_chk: RTL and testbench

Parametrised parallel PRBS generator and self-synchronising checker in one block. Polynomial (PRBS7/15/23/31) is selectable at run time; W bits are produced and checked per clock. The generator drives test patterns onto output pins. The checker consumes looped-back data, acquires lock and counts bit errors. It supersedes the fixed 32-bit PRBS31 scrambler in the top-level test harness.

---
 rtl/prbs_pkg.sv | 78 +++++++
 rtl/prbs_gen_chk_step.sv | 24 ++
 rtl/prbs_gen_chk.sv | 170 +++++++++++++++++
 tb/tb_prbs_gen_chk.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/prbs_pkg.sv
// Shared PRBS definitions: polynomial selection, tap constants and the
// W-bit lookahead step used by both the generator and the checker predictor.
package prbs_pkg;

    typedef enum logic [1:0] {
        PRBS7  = 2'b00,
        PRBS15 = 2'b01,
        PRBS23 = 2'b10,
        PRBS31 = 2'b11
    } prbs_mode_e;

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } chk_state_e;

    localparam int PRBS7_N  = 7;
    localparam int PRBS7_A  = 6;
    localparam int PRBS15_N = 15;
    localparam int PRBS15_A = 14;
    localparam int PRBS23_N = 23;
    localparam int PRBS23_A = 18;
    localparam int PRBS31_N = 31;
    localparam int PRBS31_A = 28;

    typedef struct packed {
        logic [31:0] bits;
        logic [30:0] hist;
    } prbs_step_t;

    // hist[0] is the most recent bit, so hist[k-1] is x[n-k].
    function automatic logic prbs_feedback(input logic [30:0] h, input prbs_mode_e m);
        case (m)
            PRBS7:   return h[PRBS7_N-1]  ^ h[PRBS7_A-1];
            PRBS15:  return h[PRBS15_N-1] ^ h[PRBS15_A-1];
            PRBS23:  return h[PRBS23_N-1] ^ h[PRBS23_A-1];
            default: return h[PRBS31_N-1] ^ h[PRBS31_A-1];
        endcase
    endfunction

    function automatic logic [30:0] hist_mask(input prbs_mode_e m);
        case (m)
            PRBS7:   return 31'h0000_007F;
            PRBS15:  return 31'h0000_7FFF;
            PRBS23:  return 31'h007F_FFFF;
            default: return 31'h7FFF_FFFF;
        endcase
    endfunction

    // Next w bits (first-in-time at bits[w-1]) and the history after them.
    function automatic prbs_step_t prbs_next(input logic [30:0] hist, input prbs_mode_e mode,
                                             input int w);
        prbs_step_t r;
        logic       b;
        logic [4:0] idx;
        r.bits = '0;
        r.hist = hist;
        for (int i = 0; i < 32; i++) begin
            if (i < w) begin
                b      = prbs_feedback(r.hist, mode);
                r.hist = {r.hist[29:0], b};
                idx    = 5'(w - 1 - i);
                r.bits[idx] = b;
            end
        end
        return r;
    endfunction

    function automatic logic [5:0] popcount32(input logic [31:0] v);
        logic [5:0] c;
        c = '0;
        for (int i = 0; i < 32; i++) begin
            c = c + 6'(v[i]);
        end
        return c;
    endfunction

endpackage

// File: rtl/prbs_gen_chk_step.sv
// Combinational W-bit PRBS lookahead; one copy drives the generator, one
// predicts the checker's expected word.
module prbs_par_step
    import prbs_pkg::*;
#(
    parameter int W = 8
) (
    input  logic [30:0] hist,
    input  prbs_mode_e  mode,
    output logic [W-1:0] bits,
    output logic [30:0] hist_next
);

    prbs_step_t step;
    logic       unused_lookahead;

    always_comb begin
        step             = prbs_next(hist, mode, W);
        bits             = step.bits[W-1:0];
        hist_next        = step.hist;
        unused_lookahead = ^step.bits;
    end

endmodule

// File: rtl/prbs_gen_chk.sv
// Run-time selectable parallel PRBS generator plus self-synchronising checker
// with lock acquisition, loss-of-lock detection and a saturating error count.
module prbs_gen_chk
    import prbs_pkg::*;
#(
    parameter int W          = 8,
    parameter int ERR_CNT_W  = 16,
    parameter int LOCK_CNT   = 8,
    parameter int UNLOCK_CNT = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic [1:0]           mode,
    input  logic                 inject_err,
    output logic [W-1:0]         gen_data,
    output logic                 gen_valid,
    input  logic [W-1:0]         chk_data,
    input  logic                 chk_valid,
    input  logic                 clr_err,
    output logic                 locked,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    localparam int MATCH_W = $clog2(LOCK_CNT + 1);
    localparam int BAD_W   = $clog2(UNLOCK_CNT + 1);
    localparam logic [MATCH_W-1:0]   LOCK_TGT   = MATCH_W'(LOCK_CNT);
    localparam logic [BAD_W-1:0]     UNLOCK_TGT = BAD_W'(UNLOCK_CNT);
    localparam logic [5:0]           BAD_THR    = 6'(W / 2);
    localparam logic [ERR_CNT_W-1:0] ERR_MAX    = '1;

    function automatic logic [ERR_CNT_W-1:0] sat_add(input logic [ERR_CNT_W-1:0] acc,
                                                     input logic [5:0] inc);
        logic [ERR_CNT_W+6:0] sum;
        sum = {7'b0, acc} + {{(ERR_CNT_W+1){1'b0}}, inc};
        return (sum > {7'b0, ERR_MAX}) ? ERR_MAX : sum[ERR_CNT_W-1:0];
    endfunction

    prbs_mode_e mode_in;
    prbs_mode_e mode_q;
    logic       mode_chg;

    assign mode_in  = prbs_mode_e'(mode);
    assign mode_chg = (mode_in != mode_q);

    // Generator: one W-bit word per enabled cycle, reseeded on mode change.
    logic [30:0]  gen_hist;
    logic [30:0]  gen_hist_nxt;
    logic [W-1:0] gen_bits;

    prbs_par_step #(.W(W)) u_gen_step (
        .hist      (gen_hist),
        .mode      (mode_q),
        .bits      (gen_bits),
        .hist_next (gen_hist_nxt)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mode_q    <= mode_in;
            gen_hist  <= '1;
            gen_data  <= '0;
            gen_valid <= 1'b0;
        end else begin
            mode_q    <= mode_in;
            gen_valid <= en && !mode_chg;
            if (mode_chg) begin
                gen_hist <= '1;
            end else if (en) begin
                gen_hist <= gen_hist_nxt;
                gen_data <= gen_bits ^ W'(inject_err);
            end
        end
    end

    // Checker: predict, compare, and track lock.
    chk_state_e          state_q, state_d;
    logic [MATCH_W-1:0]  match_q, match_d;
    logic [BAD_W-1:0]    bad_q, bad_d;
    logic [ERR_CNT_W-1:0] err_d;
    logic [30:0]         chk_hist, chk_hist_d;
    logic [30:0]         pred_hist, rx_hist;
    logic [W-1:0]        pred;
    logic [31:0]         miss;
    logic [5:0]          err_bits;
    logic                hist_nz;

    prbs_par_step #(.W(W)) u_chk_step (
        .hist      (chk_hist),
        .mode      (mode_q),
        .bits      (pred),
        .hist_next (pred_hist)
    );

    always_comb begin
        miss          = '0;
        miss[W-1:0]   = pred ^ chk_data;
        err_bits      = popcount32(miss);
        hist_nz       = |(chk_hist & hist_mask(mode_q));
        rx_hist       = chk_hist;
        for (int i = W - 1; i >= 0; i--) begin
            rx_hist = {rx_hist[29:0], chk_data[i]};
        end
    end

    always_comb begin
        state_d    = state_q;
        match_d    = match_q;
        bad_d      = bad_q;
        err_d      = err_cnt;
        chk_hist_d = chk_hist;
        if (mode_chg) begin
            state_d = SEARCH;
            match_d = '0;
            bad_d   = '0;
        end else if (chk_valid) begin
            case (state_q)
                SEARCH: begin
                    // Absorbing received bits lets the predictor self-align.
                    chk_hist_d = rx_hist;
                    if (err_bits == 6'd0 && hist_nz) begin
                        match_d = match_q + MATCH_W'(1);
                        if (match_d == LOCK_TGT) begin
                            state_d = LOCKED;
                        end
                    end else begin
                        match_d = '0;
                    end
                end
                default: begin
                    // Free-running on the prediction keeps bit errors from spreading.
                    chk_hist_d = pred_hist;
                    err_d      = sat_add(err_cnt, err_bits);
                    if (err_bits > BAD_THR) begin
                        bad_d = bad_q + BAD_W'(1);
                        if (bad_d == UNLOCK_TGT) begin
                            state_d = SEARCH;
                            bad_d   = '0;
                            match_d = '0;
                        end
                    end else begin
                        bad_d = '0;
                    end
                end
            endcase
        end
        if (clr_err) begin
            err_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= SEARCH;
            match_q  <= '0;
            bad_q    <= '0;
            err_cnt  <= '0;
            chk_hist <= '1;
        end else begin
            state_q  <= state_d;
            match_q  <= match_d;
            bad_q    <= bad_d;
            err_cnt  <= err_d;
            chk_hist <= chk_hist_d;
        end
    end

    assign locked = (state_q == LOCKED);

endmodule

// File: tb/tb_prbs_gen_chk.sv
// Bench for prbs_gen_chk: serial reference model feeding an expected-word
// queue, loopback lock/unlock, error injection, saturation and reset.
module tb_prbs_gen_chk;

    logic       clk, rst_n, en, inject_err, clr_err;
    logic [1:0] mode;
    logic [7:0] gen_data, gen_data_s, chk_data, corrupt, force_data;
    logic       gen_valid, gen_valid_s, chk_valid, locked, locked_s, lb, force_vld;
    logic [15:0] err_cnt;
    logic [3:0]  err_cnt_s;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] exp_q[$];
    bit         seq[$];
    int         tap_n, tap_a;

    assign chk_data  = lb ? (gen_data ^ corrupt) : force_data;
    assign chk_valid = lb ? gen_valid : force_vld;

    prbs_gen_chk #(.W(8), .ERR_CNT_W(16), .LOCK_CNT(8), .UNLOCK_CNT(4)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .inject_err(inject_err),
        .gen_data(gen_data), .gen_valid(gen_valid), .chk_data(chk_data),
        .chk_valid(chk_valid), .clr_err(clr_err), .locked(locked), .err_cnt(err_cnt)
    );

    prbs_gen_chk #(.W(8), .ERR_CNT_W(4), .LOCK_CNT(8), .UNLOCK_CNT(4)) dut_sat (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .inject_err(inject_err),
        .gen_data(gen_data_s), .gen_valid(gen_valid_s), .chk_data(chk_data),
        .chk_valid(chk_valid), .clr_err(clr_err), .locked(locked_s), .err_cnt(err_cnt_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // Bit-serial definition: x[n] = x[n-A] ^ x[n-N], seeded with N ones.
    function automatic void ref_reset(input int m);
        case (m)
            0:       begin tap_n = 7;  tap_a = 6;  end
            1:       begin tap_n = 15; tap_a = 14; end
            2:       begin tap_n = 23; tap_a = 18; end
            default: begin tap_n = 31; tap_a = 28; end
        endcase
        seq.delete();
        for (int i = 0; i < tap_n; i++) seq.push_back(1'b1);
    endfunction

    function automatic logic [7:0] ref_word();
        logic [7:0] w;
        bit         b;
        int         n;
        w = '0;
        for (int i = 0; i < 8; i++) begin
            n = seq.size();
            b = seq[n-tap_a] ^ seq[n-tap_n];
            seq.push_back(b);
            w = {w[6:0], b};
        end
        while (seq.size() > 64) void'(seq.pop_front());
        return w;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        lb = 1'b1; corrupt = 8'h00; force_data = 8'h00; force_vld = 1'b0;
        en = 1'b0; inject_err = 1'b0; clr_err = 1'b0; mode = 2'b00; rst_n = 1'b0;
        step(); step();
        n_checks++; if (gen_data !== 8'h00) begin n_fail++; $display("FAIL reset_gen_data got=%h exp=00", gen_data); end
        n_checks++; if (gen_valid !== 1'b0) begin n_fail++; $display("FAIL reset_gen_valid got=%b exp=0", gen_valid); end
        n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL reset_locked got=%b exp=0", locked); end
        n_checks++; if (err_cnt !== 16'h0) begin n_fail++; $display("FAIL reset_err_cnt got=%0d exp=0", err_cnt); end
        n_checks++; if (err_cnt_s !== 4'h0) begin n_fail++; $display("FAIL reset_err_cnt_sat got=%0d exp=0", err_cnt_s); end
        n_checks++; if (gen_data_s !== 8'h00 || gen_valid_s !== 1'b0) begin n_fail++; $display("FAIL reset_sat_gen got=%h/%b exp=00/0", gen_data_s, gen_valid_s); end
        rst_n = 1'b1;
        ref_reset(0);
        exp_q.delete();
    endtask

    task automatic test_golden();
        logic [7:0] ew;
        bit         obs[$];
        int         per_bad;
        ew = 8'h00;
        for (int k = 0; k < 32; k++) begin
            en = 1'b1;
            exp_q.push_back(ref_word());
            step();
            n_checks++;
            if (gen_valid !== 1'b1) begin
                n_fail++; $display("FAIL golden_valid word=%0d got=%b exp=1", k, gen_valid);
            end else begin
                ew = exp_q.pop_front();
                n_checks++;
                if (gen_data !== ew) begin n_fail++; $display("FAIL golden_word word=%0d got=%h exp=%h", k, gen_data, ew); end
                for (int b = 7; b >= 0; b--) obs.push_back(gen_data[b]);
            end
            if (k == 0) begin
                n_checks++; if (gen_data !== 8'h02) begin n_fail++; $display("FAIL golden_first got=%h exp=02", gen_data); end
            end
        end
        en = 1'b0;
        step();
        n_checks++; if (gen_valid !== 1'b0) begin n_fail++; $display("FAIL gen_idle_valid got=%b exp=0", gen_valid); end
        n_checks++; if (gen_data !== ew) begin n_fail++; $display("FAIL gen_idle_hold got=%h exp=%h", gen_data, ew); end
        per_bad = 0;
        if (obs.size() < 254) per_bad = -1;
        else for (int i = 0; i < 127; i++) if (obs[i] !== obs[i+127]) per_bad++;
        n_checks++; if (per_bad != 0) begin n_fail++; $display("FAIL golden_period got=%0d bad bits exp=0", per_bad); end
    endtask

    task automatic test_lock();
        int         words, sb_bad, lk_bad;
        bit         pv;
        logic [7:0] ew;
        mode = 2'b11; rst_n = 1'b0; en = 1'b0;
        step();
        rst_n = 1'b1;
        ref_reset(3);
        exp_q.delete();
        words = 0; sb_bad = 0; lk_bad = 0;
        for (int k = 0; k < 12; k++) begin
            en = 1'b1;
            exp_q.push_back(ref_word());
            pv = chk_valid;
            step();
            if (pv) words++;
            n_checks++;
            if (locked !== (words >= 8)) begin n_fail++; $display("FAIL lock_timing words=%0d got=%b exp=%b", words, locked, words >= 8); end
            if (gen_valid) begin ew = exp_q.pop_front(); if (gen_data !== ew) sb_bad++; end
        end
        for (int k = 0; k < 10000; k++) begin
            en = ($urandom_range(0, 7) != 0);
            if (en) exp_q.push_back(ref_word());
            step();
            if (gen_valid) begin ew = exp_q.pop_front(); if (gen_data !== ew) sb_bad++; end
            if (err_cnt !== 16'h0 || locked !== 1'b1) lk_bad++;
        end
        en = 1'b1;
        n_checks++; if (sb_bad != 0) begin n_fail++; $display("FAIL prbs31_words got=%0d wrong exp=0", sb_bad); end
        n_checks++; if (lk_bad != 0) begin n_fail++; $display("FAIL loopback_clean got=%0d bad cycles exp=0", lk_bad); end
        n_checks++; if (err_cnt !== 16'h0) begin n_fail++; $display("FAIL loopback_err got=%0d exp=0", err_cnt); end
    endtask

    task automatic test_inject();
        int         sb_bad;
        logic [7:0] ew;
        sb_bad = 0;
        en = 1'b1;
        for (int p = 0; p < 3; p++) begin
            inject_err = 1'b1;
            exp_q.push_back(ref_word() ^ 8'h01);
            step();
            inject_err = 1'b0;
            if (gen_valid) begin ew = exp_q.pop_front(); if (gen_data !== ew) sb_bad++; end else sb_bad++;
            repeat (3) begin
                exp_q.push_back(ref_word());
                step();
                if (gen_valid) begin ew = exp_q.pop_front(); if (gen_data !== ew) sb_bad++; end else sb_bad++;
            end
        end
        n_checks++; if (sb_bad != 0) begin n_fail++; $display("FAIL inject_words got=%0d wrong exp=0", sb_bad); end
        n_checks++; if (err_cnt !== 16'd3) begin n_fail++; $display("FAIL inject_count got=%0d exp=3", err_cnt); end
        n_checks++; if (err_cnt_s !== 4'd3) begin n_fail++; $display("FAIL inject_count_sat got=%0d exp=3", err_cnt_s); end
        n_checks++; if (locked !== 1'b1) begin n_fail++; $display("FAIL inject_locked got=%b exp=1", locked); end
        inject_err = 1'b1;
        exp_q.push_back(ref_word() ^ 8'h01);
        step();
        inject_err = 1'b0;
        clr_err = 1'b1;
        exp_q.push_back(ref_word());
        step();
        clr_err = 1'b0;
        exp_q.push_back(ref_word());
        step();
        n_checks++; if (err_cnt !== 16'd0) begin n_fail++; $display("FAIL clr_priority got=%0d exp=0", err_cnt); end
        exp_q.delete();
    endtask

    task automatic test_unlock();
        en = 1'b1;
        corrupt = 8'hFF;
        for (int b = 1; b <= 4; b++) begin
            step();
            n_checks++;
            if (locked !== (b < 4)) begin n_fail++; $display("FAIL unlock bad_words=%0d got=%b exp=%b", b, locked, b < 4); end
        end
        corrupt = 8'h00;
        for (int w = 1; w <= 8; w++) begin
            step();
            n_checks++;
            if (locked !== (w == 8)) begin n_fail++; $display("FAIL relock words=%0d got=%b exp=%b", w, locked, w == 8); end
        end
    endtask

    task automatic test_zero_mode();
        int         seen, t;
        logic [7:0] ew;
        mode = 2'b00; rst_n = 1'b0; en = 1'b0;
        step();
        rst_n = 1'b1;
        lb = 1'b0; force_data = 8'h00; force_vld = 1'b1;
        seen = 0;
        repeat (100) begin step(); if (locked !== 1'b0) seen++; end
        n_checks++; if (seen != 0) begin n_fail++; $display("FAIL zero_input_lock got=%0d locked cycles exp=0", seen); end
        lb = 1'b1; force_vld = 1'b0; en = 1'b1;
        t = 0;
        while (locked !== 1'b1 && t < 40) begin step(); t++; end
        n_checks++; if (locked !== 1'b1) begin n_fail++; $display("FAIL prbs7_lock got=%b exp=1", locked); end
        mode = 2'b10;
        step();
        n_checks++; if (gen_valid !== 1'b0) begin n_fail++; $display("FAIL mode_chg_valid got=%b exp=0", gen_valid); end
        n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL mode_chg_locked got=%b exp=0", locked); end
        ref_reset(2);
        exp_q.push_back(ref_word());
        step();
        ew = exp_q.pop_front();
        n_checks++; if (gen_valid !== 1'b1 || gen_data !== ew) begin n_fail++; $display("FAIL prbs23_first got=%h/%b exp=%h/1", gen_data, gen_valid, ew); end
        t = 0;
        while (locked !== 1'b1 && t < 40) begin step(); t++; end
        n_checks++; if (locked !== 1'b1) begin n_fail++; $display("FAIL prbs23_relock got=%b exp=1", locked); end
        repeat (50) step();
        n_checks++; if (err_cnt !== 16'd0) begin n_fail++; $display("FAIL prbs23_clean got=%0d exp=0", err_cnt); end
    endtask

    task automatic test_sat();
        en = 1'b1;
        inject_err = 1'b1;
        repeat (30) step();
        inject_err = 1'b0;
        repeat (3) step();
        n_checks++; if (err_cnt_s !== 4'd15) begin n_fail++; $display("FAIL sat_count got=%0d exp=15", err_cnt_s); end
        n_checks++; if (err_cnt !== 16'd30) begin n_fail++; $display("FAIL wide_count got=%0d exp=30", err_cnt); end
        n_checks++; if (locked !== 1'b1 || locked_s !== 1'b1) begin n_fail++; $display("FAIL sat_locked got=%b/%b exp=1/1", locked, locked_s); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] ew;
        en = 1'b1;
        rst_n = 1'b0;
        step();
        n_checks++; if (gen_data !== 8'h00 || gen_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_gen got=%h/%b exp=00/0", gen_data, gen_valid); end
        n_checks++; if (locked !== 1'b0 || locked_s !== 1'b0) begin n_fail++; $display("FAIL midreset_locked got=%b/%b exp=0/0", locked, locked_s); end
        n_checks++; if (err_cnt !== 16'd0 || err_cnt_s !== 4'd0) begin n_fail++; $display("FAIL midreset_err got=%0d/%0d exp=0/0", err_cnt, err_cnt_s); end
        rst_n = 1'b1;
        ref_reset(2);
        exp_q.delete();
        exp_q.push_back(ref_word());
        step();
        ew = exp_q.pop_front();
        n_checks++; if (gen_valid !== 1'b1 || gen_data !== ew) begin n_fail++; $display("FAIL midreset_reseed got=%h/%b exp=%h/1", gen_data, gen_valid, ew); end
    endtask

    initial begin
        test_reset();
        test_golden();
        test_lock();
        test_inject();
        test_unlock();
        test_zero_mode();
        test_sat();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
